serial_magnitude_comparator: RTL and testbench

- Bit-serial N-bit unsigned magnitude comparator built on the 1-bit lt/gt/eq compare stage.
- Loads two WIDTH-bit operands and walks them MSB-first, feeding one bit pair per cycle into a 1-bit compare.
- Stops at the first differing bit (early exit) and reports registered lt/gt/eq with a done pulse.
- Sits downstream of the 1-bit comparator and consumes its per-bit lt/gt/eq outputs. Trades latency for area in multi-bit compares.

---
 rtl/serial_magnitude_comparator.sv | 123 ++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: walks two operands MSB-first through a
// 1-bit compare stage and stops at the first differing bit.

module bit_compare (
    input  logic a,
    input  logic b,
    output logic lt,
    output logic gt,
    output logic eq
);
    assign lt = ~a & b;
    assign gt = a & ~b;
    assign eq = ~(a ^ b);
endmodule

module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             bit_lt, bit_gt, bit_eq;

    bit_compare u_bit (
        .a  (sa_q[WIDTH-1]),
        .b  (sb_q[WIDTH-1]),
        .lt (bit_lt),
        .gt (bit_gt),
        .eq (bit_eq)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a_in;
                    sb_d    = b_in;
                    cnt_d   = CW'(WIDTH);
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_gt) begin
                    gt_d    = 1'b1;
                    state_d = DONE;
                end else if (bit_lt) begin
                    lt_d    = 1'b1;
                    state_d = DONE;
                end else if (bit_eq && cnt_q == CW'(1)) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    sa_d  = {sa_q[WIDTH-2:0], 1'b0};
                    sb_d  = {sb_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status flags are registered from the next state so they line up with it.
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lt   = lt_q;
    assign gt   = gt_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator: vector table, corner-case
// sequences and randomized compares against an arithmetic reference model.

module tb_serial_magnitude_comparator;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy, done, lt, gt, eq;

    int tests  = 0;
    int errors = 0;

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .lt    (lt),
        .gt    (gt),
        .eq    (eq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         elt;
        logic         egt;
        logic         eeq;
        int           lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Result from plain comparison; latency from the highest differing bit index.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic elt, output logic egt,
                                  output logic eeq, output int lat);
        elt = (a < b);
        egt = (a > b);
        eeq = (a == b);
        lat = W + 1;
        for (int k = 0; k < W; k++)
            if (a[k] != b[k]) lat = W - k + 1;
    endfunction

    task automatic do_compare(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic elt, input logic egt, input logic eeq, input int lat);
        int   got_lat;
        bit   bad;
        logic [2:0] res;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        got_lat = 0;
        bad     = 0;
        for (int c = 1; c <= W + 4 && got_lat == 0; c++) begin
            @(negedge clk);
            if (done) got_lat = c;
            else if (!busy || lt || gt || eq) bad = 1;
        end
        res = {lt, gt, eq};
        check({name, " latency"}, got_lat, lat);
        check({name, " result"}, int'(res), int'({elt, egt, eeq}));
        check({name, " busy at done"}, int'(busy), 0);
        check({name, " in-flight flags"}, int'(bad), 0);
        $display("[TB] %s a=%02h b=%02h -> lt=%0d gt=%0d eq=%0d lat=%0d", name, a, b,
                 lt, gt, eq, got_lat);
        @(negedge clk);
        check({name, " done one cycle"}, int'(done), 0);
        check({name, " result held"}, int'({lt, gt, eq}), int'({elt, egt, eeq}));
    endtask

    initial begin
        int   done_cycles[$];
        logic elt, egt, eeq;
        int   lat;
        logic [W-1:0] ra, rb;

        vecs[0] = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 9};
        vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 2};
        vecs[2] = '{8'h12, 8'h13, 1'b1, 1'b0, 1'b0, 9};
        vecs[3] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 2};
        vecs[4] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 2};
        vecs[5] = '{8'hC0, 8'hE0, 1'b1, 1'b0, 1'b0, 4};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 9};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", int'({busy, done, lt, gt, eq}), 0);
        rst = 1'b0;

        foreach (vecs[i])
            do_compare($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                       vecs[i].elt, vecs[i].egt, vecs[i].eeq, vecs[i].lat);

        // Start re-pulsed during SHIFT must be ignored
        @(negedge clk);
        a_in = 8'h40; b_in = 8'h00; start = 1'b1;
        @(posedge clk);
        #1;
        a_in = 8'h00; b_in = 8'hFF;
        @(negedge clk);
        check("ignore c1 busy", int'({busy, done}), 2);
        @(negedge clk);
        check("ignore c2 busy", int'({busy, done}), 2);
        @(negedge clk);
        start = 1'b0;
        check("ignore c3 done", int'(done), 1);
        check("ignore result", int'({lt, gt, eq}), 3'b010);
        $display("[TB] ignore-start 40 vs 00 -> lt=%0d gt=%0d eq=%0d", lt, gt, eq);

        // Reset mid-compare discards the result
        @(negedge clk);
        a_in = 8'h01; b_in = 8'h01; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid reset outputs", int'({busy, done, lt, gt, eq}), 0);
        rst = 1'b0;
        begin
            int seen = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("no done after reset", seen, 0);
        end
        $display("[TB] mid-compare reset -> discarded");
        do_compare("post-reset", 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 9);

        // Start held high: back-to-back compares
        @(negedge clk);
        a_in = 8'h03; b_in = 8'h05; start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (done) begin
                done_cycles.push_back(c);
                check($sformatf("b2b lt at %0d", c), int'({lt, gt, eq}), 3'b100);
            end
        end
        start = 1'b0;
        check("b2b done count", done_cycles.size(), 3);
        if (done_cycles.size() == 3) begin
            check("b2b first done", done_cycles[0], 7);
            check("b2b spacing 1", done_cycles[1] - done_cycles[0], 8);
            check("b2b spacing 2", done_cycles[2] - done_cycles[1], 8);
        end
        $display("[TB] back-to-back 03 vs 05 -> %0d done pulses", done_cycles.size());
        repeat (10) @(negedge clk);

        // Randomized compares, biased toward shared prefixes and equality
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0: rb = ra;
                1: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            model(ra, rb, elt, egt, eeq, lat);
            do_compare($sformatf("rand%0d", n), ra, rb, elt, egt, eeq, lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
